// File: rtl/fifo_burst_writer.sv
// Burst source for a FIFO push port: expands one {seed, step, len} command into
// len words with an incrementing payload and an end-of-burst flag on the last word.
module fifo_burst_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LEN    = 16,
  parameter int CNT_WIDTH  = 16,
  localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [DATA_WIDTH-1:0] cmd_seed_i,
  input  logic [DATA_WIDTH-1:0] cmd_step_i,
  input  logic [LEN_W-1:0]      cmd_len_i,
  output logic                  push_valid_o,
  input  logic                  push_grant_i,
  output logic [DATA_WIDTH:0]   push_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  words_sent_o
);

  // Handshake: a word moves on any posedge where push_valid_o && push_grant_i;
  // once raised, push_valid_o and push_data_o stay unchanged until that happens.
  // Commands are taken on a posedge where cmd_valid_i && cmd_ready_o.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] payload_q, payload_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic [LEN_W-1:0]      remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0]  words_q, words_d;
  logic [LEN_W-1:0]      len_clamped;
  logic                  accept;
  logic                  xfer;
  logic                  last_word;

  assign len_clamped = (cmd_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len_i;

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign push_valid_o = (state_q == S_SEND);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign words_sent_o = words_q;

  assign accept    = cmd_valid_i && cmd_ready_o;
  assign xfer      = push_valid_o && push_grant_i;
  assign last_word = (remaining_q == LEN_W'(1));

  assign push_data_o = push_valid_o ? {last_word, payload_q} : '0;

  always_comb begin
    state_d     = state_q;
    payload_d   = payload_q;
    step_d      = step_q;
    remaining_d = remaining_q;
    words_d     = words_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          payload_d   = cmd_seed_i;
          step_d      = cmd_step_i;
          remaining_d = len_clamped;
          state_d     = (len_clamped == '0) ? S_DONE : S_SEND;
        end
      end
      S_SEND: begin
        if (xfer) begin
          payload_d   = payload_q + step_q;
          remaining_d = remaining_q - LEN_W'(1);
          words_d     = words_q + CNT_WIDTH'(1);
          if (last_word) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      payload_q   <= '0;
      step_q      <= '0;
      remaining_q <= '0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      payload_q   <= payload_d;
      step_q      <= step_d;
      remaining_q <= remaining_d;
      words_q     <= words_d;
    end
  end

endmodule
